// File: rtl/serial_adder_if.sv
// Start/ready request and done/result bus of serial_adder.
// The sub signal and its modport entries exist only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             done;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, A, B, C_in, sub, input ready, S, C_out, done);
  modport slave  (input start, A, B, C_in, sub, output ready, S, C_out, done);
`else
  modport master (output start, A, B, C_in, input ready, S, C_out, done);
  modport slave  (input start, A, B, C_in, output ready, S, C_out, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per cycle through a ripple of full-adder cells.
// Optional subtract path is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_s;
  logic [DIGIT:0]   rip;
  logic [31:0]      shamt;

  // Latched operands shift right each RUN cycle, so the active digit is always at bit 0.
  assign dig_a  = a_q[DIGIT-1:0];
  assign dig_b  = b_q[DIGIT-1:0];
  assign rip[0] = carry_q;
  assign shamt  = 32'(cnt_q) * 32'(DIGIT);

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign dig_s[gi]  = dig_a[gi] ^ dig_b[gi] ^ rip[gi];
    assign rip[gi+1]  = (dig_a[gi] & dig_b[gi]) | (rip[gi] & (dig_a[gi] ^ dig_b[gi]));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
`ifdef SERIAL_ADD_SUB_EN
          b_d     = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub | bus.C_in;
`else
          b_d     = bus.B;
          carry_d = bus.C_in;
`endif
          s_d     = '0;
          c_out_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // S was cleared on start, so OR-ing the digit in leaves higher bits at zero.
        s_d     = s_q | (WIDTH'(dig_s) << shamt);
        carry_d = rip[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          c_out_d = rip[DIGIT];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE) && !rst;
  assign bus.done  = (state_q == ST_DONE);
  assign bus.S     = s_q;
  assign bus.C_out = c_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results, monitor pops on done.
module tb_serial_adder;
  parameter int WIDTH = 8;
  parameter int DIGIT = 1;
  localparam int N = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();
  serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Reference: plain integer add, or unsigned subtract with C_out = no-borrow.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic sb);
    logic [WIDTH-1:0] diff;
    if (sb) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  endfunction

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin
    exp_t e;
    int   j;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", 64'(bus.done), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 64'(cyc), 64'(e.acc + N));
            check("sum_S", 64'(bus.S), 64'(e.s));
            check("carry_C_out", 64'(bus.C_out), 64'(e.c));
            check("ready_in_done", 64'(bus.ready), 64'd0);
          end
        end else if (exp_q.size() > 0) begin
          e = exp_q[0];
          j = cyc - e.acc;
          check("ready_while_busy", 64'(bus.ready), 64'd0);
          if (j >= N) begin
            check("missing_done", 64'(bus.done), 64'd1);
            void'(exp_q.pop_front());
          end else begin
            check("upper_S_zero", 64'(bus.S >> (j * DIGIT)), 64'd0);
          end
        end
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sb);
    int          waitc = 0;
    logic [WIDTH:0] r;
    logic        eff_sub;
`ifdef SERIAL_ADD_SUB_EN
    eff_sub = sb;
`else
    eff_sub = 1'b0;
`endif
    @(negedge clk);
    while (!bus.ready) begin
      if (waitc++ > 100) begin
        check("ready_timeout", 64'(bus.ready), 64'd1);
        return;
      end
      @(negedge clk);
    end
    bus.A     = a;
    bus.B     = b;
    bus.C_in  = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sb;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    r = model(a, b, cin, eff_sub);
    exp_q.push_back('{s: r[WIDTH-1:0], c: r[WIDTH], acc: cyc});
    vectors++;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble inputs: only the latched copies may matter from here on.
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
    bus.C_in  = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'($urandom);
`endif
  endtask

  task automatic wait_idle();
    int waitc = 0;
    @(negedge clk);
    while (exp_q.size() != 0 || !bus.ready) begin
      if (waitc++ > 200) begin
        check("idle_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int w;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.C_in  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 64'(bus.ready), 64'd1);
    check("post_reset_S", 64'(bus.S), 64'd0);
    check("post_reset_C_out", 64'(bus.C_out), 64'd0);
    check("post_reset_done", 64'(bus.done), 64'd0);

    // Directed cases
    run_op(WIDTH'(8'hFF), WIDTH'(8'h01), 1'b0, 1'b0);
    run_op(WIDTH'(8'h5A), WIDTH'(8'h3C), 1'b1, 1'b0);
    run_op(WIDTH'(8'h9F), WIDTH'(8'h71), 1'b0, 1'b0);
    run_op('0, '0, 1'b0, 1'b0);
    run_op('1, '1, 1'b1, 1'b0);
    wait_idle();

    // Start while busy must be ignored
    run_op(WIDTH'(8'h10), WIDTH'(8'h20), 1'b0, 1'b0);
    for (int i = 0; i < N - 1; i++) begin
      bus.A = WIDTH'(8'h01);
      bus.B = WIDTH'(8'h01);
      bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();

    // Reset on the 4th RUN edge (or the last one for short operations)
    w = (N - 1 < 3) ? N - 1 : 3;
    run_op(WIDTH'(8'hA5), WIDTH'(8'h5A), 1'b1, 1'b0);
    repeat (w) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_ready_in_reset", 64'(bus.ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_S", 64'(bus.S), 64'd0);
    check("abort_C_out", 64'(bus.C_out), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd1);
    run_op(WIDTH'(8'h02), WIDTH'(8'h03), 1'b0, 1'b0);
    wait_idle();

`ifdef SERIAL_ADD_SUB_EN
    run_op(WIDTH'(8'h10), WIDTH'(8'h01), 1'b0, 1'b1);
    run_op(WIDTH'(8'h01), WIDTH'(8'h02), 1'b0, 1'b1);
    run_op(WIDTH'(8'h10), WIDTH'(8'h01), 1'b1, 1'b1);
    run_op(WIDTH'(8'h01), WIDTH'(8'h02), 1'b1, 1'b1);
    wait_idle();
`endif

    // Exhaustive for small widths, randomized otherwise; back-to-back issue.
    if (WIDTH <= 4) begin
      for (int a = 0; a < (1 << WIDTH); a++)
        for (int b = 0; b < (1 << WIDTH); b++)
          for (int c = 0; c < 2; c++)
            run_op(WIDTH'(a), WIDTH'(b), 1'(c), 1'($urandom));
    end else begin
      for (int i = 0; i < 80; i++)
        run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle through a DIGIT-bit ripple of full-adder cells. Operands are latched on a start/ready handshake. The result is reported with a one-cycle done pulse. It is the area-lean, sequential successor of the team's single-bit combinational full adder and serves as the arithmetic unit for the later accumulator and multiplier blocks.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1
- DIGIT, 1, bits processed per cycle; must divide WIDTH; DIGIT = WIDTH gives single-cycle operation

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when ready = 1
- A  input  WIDTH  operand A; latched on accepted start
- B  input  WIDTH  operand B; latched on accepted start
- C_in  input  1  carry-in; latched on accepted start
- sub  input  1  subtract select; latched on accepted start; present only with SERIAL_ADD_SUB_EN
- ready  output  1  high in IDLE; start is accepted only when this is high
- S  output  WIDTH  sum; holds its value until the next accepted start
- C_out  output  1  carry out of the MSB; held with S
- done  output  1  one-cycle pulse; S and C_out are valid while it is high

## Operation
- Define N = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
- IDLE: ready = 1.
  - start = 1 at an edge latches A, B, C_in (and sub) into internal registers.
  - The same edge clears S to 0, loads the running carry with C_in, clears the digit counter, and moves to RUN.
- RUN: each edge adds digit i (bits i·DIGIT to i·DIGIT+DIGIT−1) of the latched A and B plus the running carry.
  - The DIGIT-bit result is written into the same bit positions of S.
  - The digit's carry-out replaces the running carry, and the counter increments.
  - On the edge that processes digit N−1, C_out takes the final carry and the FSM moves to DONE.
- DONE: done = 1 and ready = 0 for exactly one cycle; the next edge moves to IDLE.
- start is ignored outside IDLE; it is neither queued nor able to corrupt the operation in flight.
- A, B, C_in and sub may change freely after acceptance; only the latched copies are used.
- Arithmetic: {C_out, S} = A + B + C_in, mod 2^(WIDTH+1). S bits above the current digit read 0 during RUN.
- Reset values: ready = 0 during the reset cycle and 1 after it; S = 0, C_out = 0, done = 0; FSM = IDLE; counter = 0.
- Reset mid-RUN or in DONE aborts the operation with no done pulse. rst takes priority over start in the same cycle.

## Timing
- start accepted at edge k → RUN covers edges k+1 … k+N → done is high in the cycle after edge k+N → ready is high again after edge k+N+1.
- Start-to-done latency: N cycles. Maximum throughput: one operation per N+1 cycles.
- The earliest next start is sampled at edge k+N+1, i.e. in the cycle where ready has just risen.
- WIDTH = DIGIT: N = 1, one RUN cycle, then DONE.
- Critical path: a DIGIT-bit ripple carry plus the counter compare.

## Configuration
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - The sub port exists.
  - An accepted start with sub = 1 latches ~B and forces the initial carry to 1, ignoring C_in.
  - Result is S = A − B mod 2^WIDTH; C_out = 1 means no borrow (A ≥ B unsigned).
  - sub = 0 behaves exactly as the add path.
- Undefined: the sub port is absent; add only; no inverter or mux logic is synthesised.

## Test plan
Parameters are WIDTH = 8, DIGIT = 1 unless stated otherwise.
- Add with full carry ripple: A = 8'hFF, B = 8'h01, C_in = 0, start at edge k → S = 8'h00, C_out = 1, done high only in the cycle after edge k+8, ready high after edge k+9.
- Add with carry-in: A = 8'h5A, B = 8'h3C, C_in = 1 → S = 8'h97, C_out = 0. Then an exhaustive sweep over the 4-bit space with WIDTH = 4 against a reference model.
- Start while busy: assert start with A = 8'h01, B = 8'h01 mid-RUN of 8'h10 + 8'h20 → S = 8'h30 and only one done pulse; ready stays 0 throughout.
- Reset mid-operation: rst = 1 at the 4th RUN edge → S = 0, C_out = 0, done never pulses, ready = 1 after rst deasserts. A following 8'h02 + 8'h03 gives 8'h05.
- Digit mode: WIDTH = 8, DIGIT = 4, A = 8'h9F, B = 8'h71 → S = 8'h10, C_out = 1, done 2 cycles after start. Repeat with DIGIT = 8 → done 1 cycle after start.
- With SERIAL_ADD_SUB_EN defined:
  - sub = 1, 8'h10 − 8'h01 → S = 8'h0F, C_out = 1.
  - sub = 1, 8'h01 − 8'h02 → S = 8'hFF, C_out = 0.
  - sub = 1 with C_in = 1 gives the same results (C_in is ignored).
